uart_rx_frame: RTL and testbench

UART 8N1 receiver and the counterpart of the TX path. It sits on the FPGA UART input pin and delivers received bytes to the host-interface logic that loads weights and activations into the accelerator. The block synchronizes the serial line, detects the start bit, and samples each bit at mid-period using an internal baud counter. It reports each byte with a one-cycle valid pulse, or raises a one-cycle frame-error pulse if the stop bit is bad.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_band_gen.sv | 38 +++
 rtl/uart_rx_frame.sv | 143 ++++++++++++++
 tb/tb_uart_rx_frame.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// State encoding, rate defaults and frame geometry.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    localparam int unsigned SYS_RATE_DEF  = 100000000;
    localparam int unsigned BAND_RATE_DEF = 921600;
    localparam int unsigned DATA_BITS     = 8;
    localparam int unsigned CNT_W         = 14;

    function automatic int unsigned cycles_per_bit(
        input int unsigned sys_rate,
        input int unsigned band_rate
    );
        return sys_rate / band_rate;
    endfunction

endpackage

// File: rtl/uart_rx_band_gen.sv
// Baud counter for the UART receiver.
// Emits a one-cycle sample_tick at half or full bit period.
module uart_rx_band_gen
    import uart_pkg::*;
#(
    parameter int unsigned CNT_BAND = 108,
    parameter int unsigned CNT_HALF = 54
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic half_sel,
    output logic sample_tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] limit;

    // Wrapping on the tick also clears the count for the next state.
    always_comb begin
        limit       = half_sel ? CNT_W'(CNT_HALF - 1) : CNT_W'(CNT_BAND - 1);
        sample_tick = run && (cnt_q == limit);
        cnt_d       = cnt_q + CNT_W'(1);
        if (!run || sample_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART 8N1 receiver: synchronizer, framing FSM and byte output.
// Delivers bytes with a valid pulse or flags a bad stop bit.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned SYS_RATE  = SYS_RATE_DEF,
    parameter int unsigned BAND_RATE = BAND_RATE_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int unsigned CNT_BAND = cycles_per_bit(SYS_RATE, BAND_RATE);
    localparam int unsigned CNT_HALF = CNT_BAND / 2;
    localparam int unsigned IDX_W    = $clog2(DATA_BITS);

    logic sync1_q;
    logic sync2_q;
    logic rx_s;

    rx_state_e state_q;
    rx_state_e state_d;

    logic [IDX_W-1:0]     bit_idx_q;
    logic [IDX_W-1:0]     bit_idx_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [DATA_BITS-1:0] rx_data_q;
    logic [DATA_BITS-1:0] rx_data_d;
    logic                 rx_valid_q;
    logic                 rx_valid_d;
    logic                 frame_err_q;
    logic                 frame_err_d;

    logic run;
    logic half_sel;
    logic sample_tick;

    assign rx_s     = sync2_q;
    assign run      = (state_q == ST_START) || (state_q == ST_DATA) ||
                      (state_q == ST_STOP);
    assign half_sel = (state_q == ST_START);

    uart_rx_band_gen #(
        .CNT_BAND (CNT_BAND),
        .CNT_HALF (CNT_HALF)
    ) u_band_gen (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .half_sel    (half_sel),
        .sample_tick (sample_tick)
    );

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // A line that is high again at mid-start was a glitch.
                if (sample_tick) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            ST_DATA: begin
                if (sample_tick) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (sample_tick) begin
                    if (rx_s) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= ST_IDLE;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 108 clocks per bit.
// Expected values are hand-derived from the frame timing.
module tb_uart_rx_frame;

    localparam int BITC = 108;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int vcount   = 0;
    int fcount   = 0;
    int both     = 0;
    int vcyc[$];
    logic [7:0] vdat[$];

    uart_rx_frame dut (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (rx_valid) begin
            vcount++;
            vcyc.push_back(cyc);
            vdat.push_back(rx_data);
        end
        if (frame_err) fcount++;
        if (rx_valid && frame_err) both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        idle(BITC);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              output int t0);
        t0 = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    int vb;
    int fb;
    int t0;
    int t1;

    initial begin
        reset = 1'b0;
        rx    = 1'b1;
        idle(3);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_valid", rx_valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_busy", rx_busy, 0);
        reset = 1'b1;
        idle(10);

        // 0x55 with latency
        vb = vcount; fb = fcount;
        send_frame(8'h55, 1'b1, t0);
        chk("t55_vcnt", vcount - vb, 1);
        chk("t55_data", rx_data, 8'h55);
        chk("t55_lat", vcyc[vcyc.size()-1] - t0, 1029);
        chk("t55_ferr", fcount - fb, 0);
        idle(30);

        // glitch
        vb = vcount; fb = fcount;
        rx = 1'b0;
        idle(20);
        rx = 1'b1;
        idle(10);
        chk("glitch_busy_mid", rx_busy, 1);
        idle(30);
        chk("glitch_busy_end", rx_busy, 0);
        idle(200);
        chk("glitch_vcnt", vcount - vb, 0);
        chk("glitch_ferr", fcount - fb, 0);
        send_frame(8'hA5, 1'b1, t0);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_vcnt", vcount - vb, 1);
        idle(50);

        // bad stop bit
        vb = vcount; fb = fcount;
        send_frame(8'h3C, 1'b0, t0);
        chk("bad_ferr", fcount - fb, 1);
        chk("bad_busy_wait", rx_busy, 1);
        rx = 1'b1;
        idle(5);
        chk("bad_busy_idle", rx_busy, 0);
        chk("bad_data_hold", rx_data, 8'hA5);
        chk("bad_vcnt", vcount - vb, 0);
        idle(50);

        // back-to-back
        vb = vcount; fb = fcount;
        send_frame(8'hA5, 1'b1, t0);
        send_frame(8'h3C, 1'b1, t1);
        chk("b2b_vcnt", vcount - vb, 2);
        chk("b2b_first", vdat[vb], 8'hA5);
        chk("b2b_second", rx_data, 8'h3C);
        chk("b2b_gap", vcyc[vb+1] - vcyc[vb], 1080);
        chk("b2b_ferr", fcount - fb, 0);
        idle(20);

        // break
        vb = vcount; fb = fcount;
        rx = 1'b0;
        idle(30 * BITC);
        chk("brk_ferr", fcount - fb, 1);
        chk("brk_vcnt", vcount - vb, 0);
        chk("brk_busy", rx_busy, 1);
        rx = 1'b1;
        idle(5);
        chk("brk_busy_idle", rx_busy, 0);
        send_frame(8'hFF, 1'b1, t0);
        chk("brk_ff_data", rx_data, 8'hFF);
        chk("brk_ff_vcnt", vcount - vb, 1);
        chk("brk_ferr_once", fcount - fb, 1);
        idle(50);

        // reset mid-frame
        vb = vcount; fb = fcount;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        rx = 1'b0;
        idle(54);
        reset = 1'b0;
        idle(1);
        chk("mrst_data", rx_data, 8'h00);
        chk("mrst_valid", rx_valid, 0);
        chk("mrst_ferr", frame_err, 0);
        chk("mrst_busy", rx_busy, 0);
        reset = 1'b1;
        rx    = 1'b1;
        idle(12 * BITC);
        chk("mrst_vcnt", vcount - vb, 0);
        chk("mrst_fcnt", fcount - fb, 0);
        send_frame(8'h81, 1'b1, t0);
        chk("m81_data", rx_data, 8'h81);
        chk("m81_vcnt", vcount - vb, 1);
        idle(20);

        chk("excl", both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
